// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared defaults, FSM encodings and entry layout for alu_result_stage
// Optional feature macro: ALU_PARITY_EN (adds a stored parity bit per entry)
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_CNT_W = 16;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    // Entry layout: {result, [parity,] carry, overflow, zero}, flags in the low bits
    localparam int unsigned E_ZERO  = 0;
    localparam int unsigned E_OVF   = 1;
    localparam int unsigned E_CARRY = 2;
`ifdef ALU_PARITY_EN
    localparam int unsigned E_PARITY = 3;
    localparam int unsigned FLAGS_W  = 4;
`else
    localparam int unsigned FLAGS_W  = 3;
`endif

    function automatic int unsigned entry_w(input int unsigned width);
        return width + FLAGS_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flags.sv
`default_nettype none
// ============================================================================
// alu_flags : combinational zero / parity derivation for one result word
// Optional feature macro: ALU_PARITY_EN (parity output)
// Revision: 1.0 - initial release
// ============================================================================
module alu_flags #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    output logic             zero
`ifdef ALU_PARITY_EN
    ,
    output logic             parity
`endif
);

    assign zero = (word == '0);
`ifdef ALU_PARITY_EN
    assign parity = ^word;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// alu_result_stage : registered ALU result/flag stage with 2-entry skid buffer
// Optional feature macro: ALU_PARITY_EN (out_parity port and stored parity)
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = ALU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
`ifdef ALU_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned ENTRY_W = entry_w(WIDTH);
    // The reset entry reads as an all-zero result, so its zero flag is set
    localparam logic [ENTRY_W-1:0] RESET_ENTRY = ENTRY_W'(1) << E_ZERO;
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    logic [1:0]         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    logic               in_hs;
    logic               out_hs;
    logic               new_zero;
    logic [ENTRY_W-1:0] new_entry;
`ifdef ALU_PARITY_EN
    logic               new_parity;
`endif

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = (state_q != ST_EMPTY) && out_ready;

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .word   (in_result),
        .zero   (new_zero)
`ifdef ALU_PARITY_EN
        ,
        .parity (new_parity)
`endif
    );

    always_comb begin
        new_entry                  = '0;
        new_entry[FLAGS_W +: WIDTH] = in_result;
        new_entry[E_CARRY]          = in_carry;
        new_entry[E_OVF]            = in_overflow;
        new_entry[E_ZERO]           = new_zero;
`ifdef ALU_PARITY_EN
        new_entry[E_PARITY]         = new_parity;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic; in_ready is registered from the next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_hs) state_d = ST_ONE;
            ST_ONE: begin
                if (in_hs && !out_hs)      state_d = ST_TWO;
                else if (!in_hs && out_hs) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_hs) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    // Buffer datapath: main always holds the oldest entry
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: if (in_hs) main_d = new_entry;
            ST_ONE: begin
                if (in_hs && out_hs) main_d = new_entry;
                else if (in_hs)      skid_d = new_entry;
            end
            ST_TWO:   if (out_hs) main_d = skid_q;
            default:  main_d = main_q;
        endcase
    end

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr)
            ovf_count_d = '0;
        else if (in_hs && in_overflow && (ovf_count_q != CNT_MAX))
            ovf_count_d = ovf_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= RESET_ENTRY;
            skid_q      <= '0;
            ovf_count_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Output logic
    always_comb begin
        out_valid    = (state_q != ST_EMPTY);
        in_ready     = in_ready_q;
        out_result   = main_q[FLAGS_W +: WIDTH];
        out_zero     = main_q[E_ZERO];
        out_carry    = main_q[E_CARRY];
        out_overflow = main_q[E_OVF];
`ifdef ALU_PARITY_EN
        out_parity   = main_q[E_PARITY];
`endif
        ovf_count    = ovf_count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_result_stage : randomized + directed bench against a FIFO-queue model
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_carry = 1'b0;
    logic             in_overflow = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_overflow;
`ifdef ALU_PARITY_EN
    logic             out_parity;
`endif
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] ovf_count;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             o;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
`ifdef ALU_PARITY_EN
        .out_parity   (out_parity),
`endif
        .ovf_clr      (ovf_clr),
        .ovf_count    (ovf_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("ovf_count", 64'(ovf_count), 64'(cnt_m));
        if (q.size() > 0) begin
            check("out_result", 64'(out_result), 64'(q[0].r));
            check("out_zero", 64'(out_zero), 64'(q[0].r == 0));
            check("out_carry", 64'(out_carry), 64'(q[0].c));
            check("out_overflow", 64'(out_overflow), 64'(q[0].o));
`ifdef ALU_PARITY_EN
            check("out_parity", 64'(out_parity), 64'(^q[0].r));
`endif
        end
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd1);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_out_overflow", 64'(out_overflow), 64'd0);
`ifdef ALU_PARITY_EN
        check("rst_out_parity", 64'(out_parity), 64'd0);
`endif
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
    endtask

    // One clock: drive at the falling edge, advance model at the rising edge, check at the next fall
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic c,
                         input logic o, input logic rdy, input logic clr);
        bit   in_hs;
        bit   out_hs;
        ent_t e;
        in_valid    = v;
        in_result   = d;
        in_carry    = c;
        in_overflow = o;
        out_ready   = rdy;
        ovf_clr     = clr;
        in_hs  = v && (q.size() < 2);
        out_hs = rdy && (q.size() > 0);
        @(posedge clk);
        if (out_hs) void'(q.pop_front());
        if (in_hs) begin
            e.r = d;
            e.c = c;
            e.o = o;
            q.push_back(e);
        end
        if (clr) cnt_m = 0;
        else if (in_hs && o && cnt_m < CNT_MAX) cnt_m++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] d;

        // Power-on reset
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // Back-to-back streaming
        cycle(1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("stream_zero", 64'(out_zero), 64'd1);
        cycle(1'b1, 32'h80000001, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stream_last", 64'(out_result), 64'h80000001);
        idle(1'b1);

        // Back-pressure: third beat must be held off until the stage drains
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head", 64'(out_result), 64'h1);
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_recover", 64'(in_ready), 64'd1);
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_third", 64'(out_result), 64'h3);
        repeat (3) idle(1'b1);

        // Steady stream with out_ready toggling
        for (int i = 0; i < 40; i++)
            cycle(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0, i[0], 1'b0);
        repeat (3) idle(1'b1);

        // Overflow counter saturation and clear priority
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        check("ovf_sat", 64'(ovf_count), 64'(CNT_MAX));
        cycle(1'b1, 32'hDEAD0001, 1'b1, 1'b1, 1'b1, 1'b1);
        check("ovf_clr_prio", 64'(ovf_count), 64'd0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            d = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        repeat (3) idle(1'b1);

        // Asynchronous reset mid-stream with both entries full
        cycle(1'b1, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_full", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        cnt_m = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        cycle(1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage sitting directly downstream of the 32-bit bitwise/arithmetic units (XOR, AND, OR, adder), capturing the selected ALU result and its flags. Provides a valid/ready handshake with full throughput and a 2-entry skid buffer so downstream back-pressure never drops a result. It also keeps a saturating count of overflow events for debug and test.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; registered.
- in_result  in  WIDTH  ALU result word.
- in_carry  in  1  carry-out from the adder path; 0 for bitwise ops.
- in_overflow  in  1  signed overflow from the adder path.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  registered result.
- out_zero  out  1  1 when out_result == 0.
- out_carry  out  1  registered carry.
- out_overflow  out  1  registered overflow.
- out_parity  out  1  XOR-reduction of out_result; present only with ALU_PARITY_EN.
- ovf_clr  in  1  synchronous clear of ovf_count.
- ovf_count  out  CNT_W  saturating count of accepted beats with in_overflow=1.

## Operation
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Storage: main register (drives outputs) and skid register. Flags (zero, parity) are computed on entry capture and stored with the entry.
- States: EMPTY, ONE (main full), TWO (main and skid full).
- EMPTY: on input handshake, load main, go ONE.
- ONE: input only: load skid, go TWO. Output only: go EMPTY. Both: load main with new entry, stay ONE. Neither: hold.
- TWO: in_ready=0, no input accepted. On output handshake: main<=skid, go ONE. Else hold.
- in_ready = (state != TWO), registered alongside the state.
- out_valid = (state != EMPTY). Output fields are stable while out_valid && !out_ready.
- Order is strictly FIFO; no entry is duplicated or dropped.
- ovf_count: +1 on each input handshake with in_overflow=1; saturates at 2^CNT_W-1. ovf_clr has priority: same-cycle clear and increment yields 0.

## Timing
- Reset (rst_n low, any time, including mid-transfer): state EMPTY, out_valid=0, in_ready=1, out_result=0, out_zero=1, out_carry=0, out_overflow=0, out_parity=0, ovf_count=0; both buffer entries discarded.
- First in_ready=1 at the first edge after rst_n deasserts.
- Latency: input handshake at edge N -> out_valid at edge N (visible the cycle after N) with that entry.
- Throughput: 1 beat/cycle while out_ready=1 continuously.
- After out_ready drops, at most one further beat is accepted (into skid); in_ready falls the cycle after.
- Recovery from TWO: in_ready returns to 1 the cycle after the first output handshake.

## Configuration
- ALU_PARITY_EN defined: out_parity port exists, parity stored per entry (both registers).
- Undefined: port and parity storage removed; all other behaviour identical.

## Structure
- Shared package alu_pkg: default WIDTH, CNT_W, state encodings (EMPTY=2'b00, ONE=2'b01, TWO=2'b10), entry field layout/width constant (result + carry + overflow + zero [+ parity]).
- One sub-module: alu_flags, combinational, computing zero and parity from a WIDTH-bit word; instantiated once on the capture path.

## Test plan
- Reset: assert rst_n low mid-stream with both entries full -> all outputs at reset values, in_ready=1, ovf_count=0.
- Streaming: out_ready=1, send 0xFFFF0000, 0x00000000, 0x80000001 back-to-back -> outputs one cycle later in order; out_zero = 0,1,0; parity (enabled) = 0,0,0.
- Back-pressure: out_ready=0, in_valid=1 with 0x1, 0x2, 0x3 -> 0x1 and 0x2 accepted, in_ready=0, 0x3 held; release out_ready -> 0x1, 0x2, 0x3 emitted in order, no loss.
- Simultaneous in/out in ONE: steady stream with out_ready toggling every cycle -> no duplicates, order preserved, state never stuck.
- Overflow counter: CNT_W=4, 20 accepted beats with in_overflow=1 -> ovf_count=15; ovf_clr with a same-cycle overflow beat -> 0.
- Config: build without ALU_PARITY_EN -> streaming test passes, out_parity absent.
